// File: rtl/scan_decoder.sv
// scan_decoder
//   Registered SEL_W-to-2**SEL_W one-hot decoder for display digit / LED
//   strobing. DIRECT mode registers the decode of an external select; SCAN
//   mode sweeps the asserted line across all outputs, advancing one line
//   every div+1 clocks.
//
// Ports
//   clk      system clock, rising edge
//   rst_n    synchronous active-low reset
//   en       1: decoder active; 0: all lines deasserted, idx/prescaler hold
//   scan     0: DIRECT mode; 1: SCAN mode
//   div      SCAN step divider (one step every div+1 clocks)
//   sel      DIRECT-mode select
//   dec_out  one-hot lines; inverted when ACTIVE_LOW != 0
//   idx      index of the currently asserted line
//   wrap     one-cycle pulse when the SCAN index wraps N-1 -> 0
module scan_decoder #(
  parameter int SEL_W      = 2,
  parameter int DIV_W      = 16,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    scan,
  input  logic [DIV_W-1:0]        div,
  input  logic [SEL_W-1:0]        sel,
  output logic [(2**SEL_W)-1:0]   dec_out,
  output logic [SEL_W-1:0]        idx,
  output logic                    wrap
);

  localparam int N = 2**SEL_W;

  // XOR mask applied at the output register; all-ones for active-low pins.
  localparam logic [N-1:0] OFF_PATTERN = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIRECT,
    ST_SCAN
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] presc_nxt;
  logic [SEL_W-1:0] idx_nxt;
  logic             wrap_nxt;
  logic [N-1:0]     lines_nxt;

  // The mode for the coming edge is taken directly from en/scan; the
  // registered state only remembers whether we were already scanning, so the
  // first SCAN edge after entry restarts the prescaler instead of stepping.
  always_comb begin
    state_nxt = ST_IDLE;
    if (en) begin
      state_nxt = scan ? ST_SCAN : ST_DIRECT;
    end

    idx_nxt   = idx;
    presc_nxt = presc;
    wrap_nxt  = 1'b0;

    case (state_nxt)
      ST_IDLE: begin
        idx_nxt   = idx;
        presc_nxt = presc;
      end
      ST_DIRECT: begin
        idx_nxt   = sel;
        presc_nxt = '0;
      end
      ST_SCAN: begin
        if (state != ST_SCAN) begin
          presc_nxt = '0;
        end else if (presc >= div) begin
          // ">=" so that lowering div mid-count steps on the next edge
          // rather than running the prescaler all the way round.
          presc_nxt = '0;
          idx_nxt   = idx + 1'b1;
          wrap_nxt  = (idx == '1);
        end else begin
          presc_nxt = presc + 1'b1;
        end
      end
      default: begin
        idx_nxt   = idx;
        presc_nxt = presc;
      end
    endcase

    lines_nxt = '0;
    if (state_nxt != ST_IDLE) begin
      lines_nxt[idx_nxt] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // dec_out and idx are loaded from the same next-state values on the same
  // edge, so they always agree.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= '0;
      presc   <= '0;
      wrap    <= 1'b0;
      dec_out <= OFF_PATTERN;
    end else begin
      idx     <= idx_nxt;
      presc   <= presc_nxt;
      wrap    <= wrap_nxt;
      dec_out <= lines_nxt ^ OFF_PATTERN;
    end
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Testbench for scan_decoder: directed scenarios plus a randomized run
// against a behavioural model. Two instances: default parameters, and
// SEL_W=3 with active-low outputs.
module tb_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        scan;
  logic [15:0] div;
  logic [1:0]  sel;
  logic [2:0]  sel3;
  logic [3:0]  dec_out;
  logic [1:0]  idx;
  logic        wrap;
  logic [7:0]  dec_out3;
  logic [2:0]  idx3;
  logic        wrap3;

  int n_checks;
  int n_fail;

  scan_decoder u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .scan    (scan),
    .div     (div),
    .sel     (sel),
    .dec_out (dec_out),
    .idx     (idx),
    .wrap    (wrap)
  );

  scan_decoder #(
    .SEL_W      (3),
    .DIV_W      (16),
    .ACTIVE_LOW (1)
  ) u_dut_al (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .scan    (scan),
    .div     (div),
    .sel     (sel3),
    .dec_out (dec_out3),
    .idx     (idx3),
    .wrap    (wrap3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model, one slot per instance. m_cnt is the number of SCAN
  // clocks already spent on the current line since entry or the last step.
  int m_idx  [2];
  int m_on   [2];
  int m_wrap [2];
  int m_scan [2];
  int m_cnt  [2];

  task automatic model_one(input int k, input int n, input int s);
    if (!rst_n) begin
      m_idx[k] = 0; m_on[k] = 0; m_wrap[k] = 0; m_scan[k] = 0; m_cnt[k] = 0;
    end else if (!en) begin
      m_on[k] = 0; m_wrap[k] = 0; m_scan[k] = 0;
    end else if (!scan) begin
      m_idx[k] = s; m_on[k] = 1; m_wrap[k] = 0; m_scan[k] = 0; m_cnt[k] = 0;
    end else begin
      m_on[k] = 1;
      m_wrap[k] = 0;
      if (m_scan[k] == 0) begin
        m_cnt[k] = 0;
      end else if (m_cnt[k] >= int'(div)) begin
        m_cnt[k] = 0;
        m_wrap[k] = (m_idx[k] == n - 1) ? 1 : 0;
        m_idx[k] = (m_idx[k] + 1) % n;
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
      end
      m_scan[k] = 1;
    end
  endtask

  function automatic logic [63:0] exp_dec(input int k, input int n, input bit al);
    logic [63:0] v;
    v = (m_on[k] != 0) ? (64'd1 << m_idx[k]) : 64'd0;
    if (al) v = ~v & ((64'd1 << n) - 64'd1);
    return v;
  endfunction

  // Advance one clock: model sees the same inputs the DUT samples at the edge.
  task automatic tick();
    model_one(0, 4, int'(sel));
    model_one(1, 8, int'(sel3));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; scan = 1'b1; div = 16'd0; sel = 2'd3; sel3 = 3'd7;
    for (int t = 0; t < 3; t++) begin
      tick();
      n_checks++;
      if (dec_out !== 4'b0000) begin
        n_fail++; $display("FAIL reset_dec t=%0d got=%b exp=0000", t, dec_out);
      end
      n_checks++;
      if (idx !== 2'd0) begin
        n_fail++; $display("FAIL reset_idx t=%0d got=%0d exp=0", t, idx);
      end
      n_checks++;
      if (wrap !== 1'b0) begin
        n_fail++; $display("FAIL reset_wrap t=%0d got=%b exp=0", t, wrap);
      end
      n_checks++;
      if (dec_out3 !== 8'hFF) begin
        n_fail++; $display("FAIL reset_dec_al t=%0d got=%h exp=ff", t, dec_out3);
      end
    end
  endtask

  task automatic test_direct();
    logic [3:0] exp_tab [4];
    exp_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rst_n = 1'b1; en = 1'b1; scan = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      tick();
      n_checks++;
      if (dec_out !== exp_tab[i]) begin
        n_fail++; $display("FAIL direct_dec sel=%0d got=%b exp=%b", i, dec_out, exp_tab[i]);
      end
      n_checks++;
      if (idx !== 2'(i)) begin
        n_fail++; $display("FAIL direct_idx sel=%0d got=%0d exp=%0d", i, idx, i);
      end
      n_checks++;
      if (wrap !== 1'b0) begin
        n_fail++; $display("FAIL direct_wrap sel=%0d got=%b exp=0", i, wrap);
      end
    end
  endtask

  task automatic test_scan_div2();
    int ei;
    en = 1'b1; scan = 1'b0; sel = 2'd0;
    tick();
    scan = 1'b1; div = 16'd2;
    for (int t = 0; t < 13; t++) begin
      tick();
      ei = (t / 3) % 4;
      n_checks++;
      if (idx !== 2'(ei)) begin
        n_fail++; $display("FAIL scan2_idx t=%0d got=%0d exp=%0d", t, idx, ei);
      end
      n_checks++;
      if (dec_out !== 4'(1 << ei)) begin
        n_fail++; $display("FAIL scan2_dec t=%0d got=%b exp=%b", t, dec_out, 4'(1 << ei));
      end
      n_checks++;
      if (wrap !== ((t == 12) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL scan2_wrap t=%0d got=%b", t, wrap);
      end
    end
  endtask

  task automatic test_en_drop();
    en = 1'b1; scan = 1'b0; sel = 2'd2;
    tick();
    scan = 1'b1; div = 16'd0;
    tick();
    en = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      n_checks++;
      if (dec_out !== 4'b0000 || idx !== 2'd2) begin
        n_fail++; $display("FAIL endrop_idle t=%0d got dec=%b idx=%0d exp dec=0000 idx=2", t, dec_out, idx);
      end
    end
    en = 1'b1;
    tick();
    n_checks++;
    if (idx !== 2'd2 || dec_out !== 4'b0100) begin
      n_fail++; $display("FAIL endrop_resume0 got idx=%0d dec=%b exp idx=2 dec=0100", idx, dec_out);
    end
    tick();
    n_checks++;
    if (idx !== 2'd3 || dec_out !== 4'b1000) begin
      n_fail++; $display("FAIL endrop_resume1 got idx=%0d dec=%b exp idx=3 dec=1000", idx, dec_out);
    end
    tick();
    n_checks++;
    if (idx !== 2'd0 || wrap !== 1'b1) begin
      n_fail++; $display("FAIL endrop_wrap got idx=%0d wrap=%b exp idx=0 wrap=1", idx, wrap);
    end
  endtask

  task automatic test_reset_midscan();
    en = 1'b1; scan = 1'b0; sel = 2'd2;
    tick();
    scan = 1'b1; div = 16'd5;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (idx !== 2'd0 || dec_out !== 4'b0000 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL midrst got idx=%0d dec=%b wrap=%b exp 0/0000/0", idx, dec_out, wrap);
    end
    rst_n = 1'b1;
    for (int t = 0; t < 7; t++) begin
      tick();
      n_checks++;
      if (idx !== ((t == 6) ? 2'd1 : 2'd0)) begin
        n_fail++; $display("FAIL midrst_sweep t=%0d got=%0d exp=%0d", t, idx, (t == 6) ? 1 : 0);
      end
    end
  endtask

  task automatic test_active_low();
    rst_n = 1'b0; en = 1'b1; scan = 1'b0; sel3 = 3'd5;
    tick();
    n_checks++;
    if (dec_out3 !== 8'hFF) begin
      n_fail++; $display("FAIL al_reset got=%h exp=ff", dec_out3);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (dec_out3 !== 8'hDF || idx3 !== 3'd5) begin
      n_fail++; $display("FAIL al_direct got dec=%h idx=%0d exp dec=df idx=5", dec_out3, idx3);
    end
    en = 1'b0;
    tick();
    n_checks++;
    if (dec_out3 !== 8'hFF || idx3 !== 3'd5) begin
      n_fail++; $display("FAIL al_idle got dec=%h idx=%0d exp dec=ff idx=5", dec_out3, idx3);
    end
  endtask

  task automatic test_random();
    logic [63:0] e0;
    logic [63:0] e1;
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      en    = ($urandom_range(0, 7) != 0);
      scan  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) div = 16'($urandom_range(0, 4));
      sel   = 2'($urandom_range(0, 3));
      sel3  = 3'($urandom_range(0, 7));
      tick();
      e0 = exp_dec(0, 4, 1'b0);
      e1 = exp_dec(1, 8, 1'b1);
      n_checks++;
      if (dec_out !== e0[3:0] || idx !== 2'(m_idx[0]) || wrap !== 1'(m_wrap[0])) begin
        n_fail++;
        $display("FAIL rnd c=%0d got dec=%b idx=%0d wrap=%b exp dec=%b idx=%0d wrap=%0d",
                 c, dec_out, idx, wrap, e0[3:0], m_idx[0], m_wrap[0]);
      end
      n_checks++;
      if (dec_out3 !== e1[7:0] || idx3 !== 3'(m_idx[1]) || wrap3 !== 1'(m_wrap[1])) begin
        n_fail++;
        $display("FAIL rnd_al c=%0d got dec=%h idx=%0d wrap=%b exp dec=%h idx=%0d wrap=%0d",
                 c, dec_out3, idx3, wrap3, e1[7:0], m_idx[1], m_wrap[1]);
      end
      n_checks++;
      if ($countones(dec_out) > 1 || $countones(~dec_out3) > 1) begin
        n_fail++; $display("FAIL rnd_onehot c=%0d got dec=%b dec_al=%h", c, dec_out, dec_out3);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; en = 1'b0; scan = 1'b0; div = '0; sel = '0; sel3 = '0;
    #1;
    test_reset();
    test_direct();
    test_scan_div2();
    test_en_drop();
    test_reset_midscan();
    test_active_low();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
